// File: rtl/flash_boot_loader_pkg.sv
// Shared loader definitions: FSM encodings, board pin polarities, kernel image size.
// Also used by the memory wrapper so both agree on the image length.
package flash_boot_loader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_LO    = 3'd1,
        RD_HI    = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic       FLASH_X16  = 1'b1;
    localparam logic       STROBE_ON  = 1'b0;
    localparam logic       STROBE_OFF = 1'b1;
    localparam logic [3:0] BE_ALL     = 4'b0000;
    localparam logic [3:0] BE_NONE    = 4'b1111;

    localparam int unsigned KERNEL_WORDS = 4210;

    // Width needed to hold values 0..n, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/flash_boot_loader_wait_timer.sv
// Loadable down-counter with a zero flag; load has priority over decrement.
// Single-cycle update, no flow control.
module flash_wait_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/flash_boot_loader.sv
// Boot-time copier: 16-bit NOR flash halfword pairs into 32-bit SRAM words.
// 2*WAIT_CYCLES+3 cycles per word; start ignored while busy; all outputs registered.
module flash_boot_loader
    import flash_boot_loader_pkg::*;
#(
    parameter int unsigned FLASH_AW    = 22,
    parameter int unsigned SRAM_AW     = 20,
    parameter int unsigned WORD_COUNT  = KERNEL_WORDS,
    parameter int unsigned WAIT_CYCLES = 8,
    parameter int unsigned SRC_BASE    = 0,
    parameter int unsigned DST_BASE    = 0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic [FLASH_AW-1:0]                 flash_addr,
    input  logic [15:0]                         flash_data_i,
    output logic                                flash_ce_n,
    output logic                                flash_oe_n,
    output logic                                flash_we_n,
    output logic                                flash_rp_n,
    output logic                                flash_byte_n,
    output logic                                flash_vpen,
    output logic [SRAM_AW-1:0]                  sram_addr,
    output logic [31:0]                         sram_wdata,
    output logic [3:0]                          sram_be_n,
    output logic                                sram_ce_n,
    output logic                                sram_oe_n,
    output logic                                sram_we_n,
    output logic                                busy,
    output logic                                done,
    output logic [cnt_width(WORD_COUNT)-1:0]    word_cnt
);

    localparam int unsigned      CNT_W  = cnt_width(WORD_COUNT);
    localparam int unsigned      TW     = cnt_width(WAIT_CYCLES - 1);
    localparam logic [TW-1:0]    RELOAD = TW'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WORD_COUNT);

    state_t              state;
    state_t              state_nxt;
    logic [31:0]         data;
    logic [31:0]         data_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [CNT_W-1:0]    cnt_inc;
    logic                go;
    logic                tmr_load;
    logic                tmr_dec;
    logic                tmr_zero;

    logic                busy_nxt;
    logic                done_nxt;
    logic                flash_ce_nxt;
    logic                flash_oe_nxt;
    logic                sram_ce_nxt;
    logic                sram_we_nxt;
    logic [3:0]          sram_be_nxt;
    logic [FLASH_AW-1:0] flash_addr_nxt;
    logic [SRAM_AW-1:0]  sram_addr_nxt;
    logic [31:0]         sram_wdata_nxt;

    assign go      = start && (state == IDLE || state == DONE);
    assign cnt_inc = word_cnt + CNT_W'(1);
    assign tmr_dec = (state == RD_LO) || (state == RD_HI);

    flash_wait_timer #(
        .WIDTH(TW)
    ) u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (RELOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    assign flash_we_n   = 1'b1;
    assign flash_byte_n = FLASH_X16;
    assign flash_vpen   = 1'b0;
    assign sram_oe_n    = STROBE_OFF;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            data       <= '0;
            word_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            flash_ce_n <= STROBE_OFF;
            flash_oe_n <= STROBE_OFF;
            flash_rp_n <= 1'b0;
            flash_addr <= FLASH_AW'(SRC_BASE);
            sram_ce_n  <= STROBE_OFF;
            sram_we_n  <= STROBE_OFF;
            sram_be_n  <= BE_NONE;
            sram_addr  <= SRAM_AW'(DST_BASE);
            sram_wdata <= '0;
        end else begin
            state      <= state_nxt;
            data       <= data_nxt;
            word_cnt   <= cnt_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            flash_ce_n <= flash_ce_nxt;
            flash_oe_n <= flash_oe_nxt;
            flash_rp_n <= 1'b1;
            flash_addr <= flash_addr_nxt;
            sram_ce_n  <= sram_ce_nxt;
            sram_we_n  <= sram_we_nxt;
            sram_be_n  <= sram_be_nxt;
            sram_addr  <= sram_addr_nxt;
            sram_wdata <= sram_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: if (start) state_nxt = (WORD_COUNT == 0) ? DONE : RD_LO;
            RD_LO:      if (tmr_zero) state_nxt = RD_HI;
            RD_HI:      if (tmr_zero) state_nxt = WR_SETUP;
            WR_SETUP:   state_nxt = WR_PULSE;
            WR_PULSE:   state_nxt = WR_HOLD;
            WR_HOLD:    state_nxt = (cnt_inc == LAST) ? DONE : RD_LO;
            default:    state_nxt = IDLE;
        endcase
    end

    // Pin values are computed from the next state so every output leaves a flop.
    always_comb begin
        tmr_load = 1'b0;
        data_nxt = data;
        cnt_nxt  = word_cnt;
        if (go && WORD_COUNT != 0) begin
            cnt_nxt  = '0;
            tmr_load = 1'b1;
        end
        if (state == RD_LO && tmr_zero) begin
            data_nxt[15:0] = flash_data_i;
            tmr_load       = 1'b1;
        end
        if (state == RD_HI && tmr_zero) begin
            data_nxt[31:16] = flash_data_i;
            tmr_load        = 1'b1;
        end
        if (state == WR_HOLD) begin
            cnt_nxt  = cnt_inc;
            tmr_load = 1'b1;
        end

        busy_nxt     = state_nxt inside {RD_LO, RD_HI, WR_SETUP, WR_PULSE, WR_HOLD};
        done_nxt     = (state_nxt == DONE);
        flash_ce_nxt = (state_nxt inside {RD_LO, RD_HI}) ? STROBE_ON : STROBE_OFF;
        flash_oe_nxt = flash_ce_nxt;
        sram_ce_nxt  = (state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD}) ? STROBE_ON : STROBE_OFF;
        sram_we_nxt  = (state_nxt == WR_PULSE) ? STROBE_ON : STROBE_OFF;
        sram_be_nxt  = (state_nxt inside {WR_SETUP, WR_PULSE, WR_HOLD}) ? BE_ALL : BE_NONE;

        flash_addr_nxt = flash_addr;
        if (state_nxt == RD_LO) begin
            flash_addr_nxt = FLASH_AW'(SRC_BASE + 2 * 32'(cnt_nxt));
        end else if (state_nxt == RD_HI) begin
            flash_addr_nxt = FLASH_AW'(SRC_BASE + 2 * 32'(cnt_nxt) + 1);
        end

        sram_addr_nxt  = sram_addr;
        sram_wdata_nxt = sram_wdata;
        if (state_nxt == WR_SETUP) begin
            sram_addr_nxt  = SRAM_AW'(DST_BASE + 32'(cnt_nxt));
            sram_wdata_nxt = data_nxt;
        end
    end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: three instances (normal, empty image, wrapping bases)
// against a queue-based reference of the expected SRAM writes.
module tb_flash_boot_loader;

    localparam int unsigned WC0 = 3, WT0 = 2, SRC0 = 0,            DST0 = 0;
    localparam int unsigned WC1 = 0, WT1 = 2, SRC1 = 0,            DST1 = 0;
    localparam int unsigned WC2 = 2, WT2 = 3, SRC2 = 32'h3F_FFFE, DST2 = 32'hF_FFFF;
    localparam int unsigned WC_A  [3] = '{WC0, WC1, WC2};
    localparam int unsigned WT_A  [3] = '{WT0, WT1, WT2};
    localparam int unsigned SRC_A [3] = '{SRC0, SRC1, SRC2};
    localparam int unsigned DST_A [3] = '{DST0, DST1, DST2};

    typedef struct {
        int          inst;
        logic [19:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start_r = 3'b000;
    logic [15:0] salt = 16'h0000;
    int          checks = 0;
    int          failures = 0;
    wr_t         exp_q[$];

    logic [2:0]  prev_we_n;
    logic [2:0]  prev_ce_n;
    logic [19:0] prev_addr  [3];
    logic [31:0] prev_wdata [3];

    wire [21:0] flash_addr_w [3];
    wire [15:0] fdata        [3];
    wire [19:0] sram_addr_w  [3];
    wire [31:0] sram_wdata_w [3];
    wire [3:0]  sram_be_n_w  [3];
    wire [2:0]  flash_ce_n_w, flash_oe_n_w, flash_we_n_w, flash_rp_n_w, flash_byte_n_w, flash_vpen_w;
    wire [2:0]  sram_ce_n_w, sram_oe_n_w, sram_we_n_w, busy_w, done_w;
    wire [1:0]  wc0;
    wire [0:0]  wc1;
    wire [1:0]  wc2;

    always #5 clk = ~clk;

    // Flash model: each halfword reads back its own address, scrambled by salt.
    for (genvar g = 0; g < 3; g++) begin : g_flash
        assign fdata[g] = flash_addr_w[g][15:0] ^ salt;
    end

    flash_boot_loader #(.FLASH_AW(22), .SRAM_AW(20), .WORD_COUNT(WC0), .WAIT_CYCLES(WT0),
                        .SRC_BASE(SRC0), .DST_BASE(DST0)) u0 (
        .clk(clk), .rst(rst), .start(start_r[0]), .flash_addr(flash_addr_w[0]), .flash_data_i(fdata[0]),
        .flash_ce_n(flash_ce_n_w[0]), .flash_oe_n(flash_oe_n_w[0]), .flash_we_n(flash_we_n_w[0]),
        .flash_rp_n(flash_rp_n_w[0]), .flash_byte_n(flash_byte_n_w[0]), .flash_vpen(flash_vpen_w[0]),
        .sram_addr(sram_addr_w[0]), .sram_wdata(sram_wdata_w[0]), .sram_be_n(sram_be_n_w[0]),
        .sram_ce_n(sram_ce_n_w[0]), .sram_oe_n(sram_oe_n_w[0]), .sram_we_n(sram_we_n_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .word_cnt(wc0));

    flash_boot_loader #(.FLASH_AW(22), .SRAM_AW(20), .WORD_COUNT(WC1), .WAIT_CYCLES(WT1),
                        .SRC_BASE(SRC1), .DST_BASE(DST1)) u1 (
        .clk(clk), .rst(rst), .start(start_r[1]), .flash_addr(flash_addr_w[1]), .flash_data_i(fdata[1]),
        .flash_ce_n(flash_ce_n_w[1]), .flash_oe_n(flash_oe_n_w[1]), .flash_we_n(flash_we_n_w[1]),
        .flash_rp_n(flash_rp_n_w[1]), .flash_byte_n(flash_byte_n_w[1]), .flash_vpen(flash_vpen_w[1]),
        .sram_addr(sram_addr_w[1]), .sram_wdata(sram_wdata_w[1]), .sram_be_n(sram_be_n_w[1]),
        .sram_ce_n(sram_ce_n_w[1]), .sram_oe_n(sram_oe_n_w[1]), .sram_we_n(sram_we_n_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .word_cnt(wc1));

    flash_boot_loader #(.FLASH_AW(22), .SRAM_AW(20), .WORD_COUNT(WC2), .WAIT_CYCLES(WT2),
                        .SRC_BASE(SRC2), .DST_BASE(DST2)) u2 (
        .clk(clk), .rst(rst), .start(start_r[2]), .flash_addr(flash_addr_w[2]), .flash_data_i(fdata[2]),
        .flash_ce_n(flash_ce_n_w[2]), .flash_oe_n(flash_oe_n_w[2]), .flash_we_n(flash_we_n_w[2]),
        .flash_rp_n(flash_rp_n_w[2]), .flash_byte_n(flash_byte_n_w[2]), .flash_vpen(flash_vpen_w[2]),
        .sram_addr(sram_addr_w[2]), .sram_wdata(sram_wdata_w[2]), .sram_be_n(sram_be_n_w[2]),
        .sram_ce_n(sram_ce_n_w[2]), .sram_oe_n(sram_oe_n_w[2]), .sram_we_n(sram_we_n_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .word_cnt(wc2));

    function automatic int wc_get(input int k);
        case (k)
            0:       return int'(wc0);
            1:       return int'(wc1);
            default: return int'(wc2);
        endcase
    endfunction

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: word i pairs flash halfwords SRC+2i (low) and SRC+2i+1 (high), lands at DST+i.
    task automatic push_expected(input int k);
        wr_t w;
        int unsigned lo, hi;
        for (int i = 0; i < int'(WC_A[k]); i++) begin
            lo     = (SRC_A[k] + 2 * i) & 32'h3F_FFFF;
            hi     = (SRC_A[k] + 2 * i + 1) & 32'h3F_FFFF;
            w.inst = k;
            w.addr = 20'((DST_A[k] + i) & 32'hF_FFFF);
            w.data = {16'(hi) ^ salt, 16'(lo) ^ salt};
            exp_q.push_back(w);
        end
    endtask

    task automatic mon_loop();
        wr_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("flash_oe_sram_ce_overlap", {flash_oe_n_w[k], sram_ce_n_w[k]} == 2'b00, 0);
                if (!sram_ce_n_w[k] && !prev_ce_n[k]) begin
                    chk("sram_addr_stable", sram_addr_w[k], prev_addr[k]);
                    chk("sram_wdata_stable", sram_wdata_w[k], prev_wdata[k]);
                end
                if (!sram_we_n_w[k]) begin
                    chk("we_pulse_one_cycle", prev_we_n[k], 1);
                    chk("we_be_n_active", sram_be_n_w[k], 0);
                    chk("write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("write_inst", k, e.inst);
                        chk("write_addr", sram_addr_w[k], e.addr);
                        chk("write_data", sram_wdata_w[k], e.data);
                    end
                end
                prev_we_n[k]  = sram_we_n_w[k];
                prev_ce_n[k]  = sram_ce_n_w[k];
                prev_addr[k]  = sram_addr_w[k];
                prev_wdata[k] = sram_wdata_w[k];
            end
            chk("empty_image_strobes_idle",
                {flash_ce_n_w[1], flash_oe_n_w[1], sram_ce_n_w[1], sram_we_n_w[1]}, 4'hF);
        end
    endtask

    task automatic run_copy(input int k, input bit repulse);
        int exp_e, got_e, rp_at;
        push_expected(k);
        exp_e = int'(WC_A[k] * (2 * WT_A[k] + 3) + 1);
        rp_at = (repulse && WC_A[k] > 0) ? int'($urandom_range(exp_e - 2, 2)) : -10;
        got_e = -1;
        @(negedge clk);
        start_r[k] = 1'b1;
        for (int e = 1; e <= exp_e + 20 && got_e < 0; e++) begin
            @(posedge clk);
            #1;
            if (e == 1) start_r[k] = 1'b0;
            if (e == rp_at) start_r[k] = 1'b1;
            if (e == rp_at + 1) start_r[k] = 1'b0;
            if (e == 1 && WC_A[k] != 0) begin
                chk("busy_after_start", busy_w[k], 1);
                chk("done_clear_after_start", done_w[k], 0);
            end
            if (done_w[k]) got_e = e;
        end
        start_r[k] = 1'b0;
        chk("done_edge", got_e, exp_e);
        chk("word_cnt_at_done", wc_get(k), WC_A[k]);
        chk("busy_at_done", busy_w[k], 0);
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        bit found;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_busy", busy_w[k], 0);
            chk("rst_done", done_w[k], 0);
            chk("rst_word_cnt", wc_get(k), 0);
            chk("rst_flash_strobes", {flash_ce_n_w[k], flash_oe_n_w[k], flash_we_n_w[k]}, 3'b111);
            chk("rst_sram_strobes", {sram_ce_n_w[k], sram_oe_n_w[k], sram_we_n_w[k]}, 3'b111);
            chk("rst_flash_rp_n", flash_rp_n_w[k], 0);
            chk("tied_byte_vpen", {flash_byte_n_w[k], flash_vpen_w[k]}, 2'b10);
            chk("rst_flash_addr", flash_addr_w[k], SRC_A[k]);
            chk("rst_sram_addr", sram_addr_w[k], DST_A[k]);
            chk("rst_sram_wdata", sram_wdata_w[k], 0);
            chk("rst_sram_be_n", sram_be_n_w[k], 4'hF);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk("rp_n_released", flash_rp_n_w[k], 1);

        prev_we_n = 3'b111;
        prev_ce_n = 3'b111;
        fork
            mon_loop();
        join_none

        // Data == address: words 0x0001_0000, 0x0003_0002, 0x0005_0004, done on edge 22.
        salt = 16'h0000;
        run_copy(0, 1'b0);
        salt = 16'($urandom);
        run_copy(0, 1'b1);

        // Reset while word 1 is in its write pulse.
        salt = 16'($urandom);
        push_expected(0);
        @(negedge clk);
        start_r[0] = 1'b1;
        @(posedge clk);
        #1;
        start_r[0] = 1'b0;
        found = 1'b0;
        for (int e = 0; e < 200 && !found; e++) begin
            if (!sram_we_n_w[0] && wc0 == 2'd1) found = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("reached_word1_pulse", found, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_we_n", sram_we_n_w[0], 1);
        chk("midrst_busy", busy_w[0], 0);
        chk("midrst_word_cnt", wc0, 0);
        chk("midrst_done", done_w[0], 0);
        exp_q.delete();
        rst = 1'b0;
        @(posedge clk);
        #1;
        salt = 16'($urandom);
        run_copy(0, 1'b0);

        run_copy(1, 1'b0);
        run_copy(1, 1'b0);

        salt = 16'($urandom);
        run_copy(2, 1'b1);

        for (int r = 0; r < 4; r++) begin
            salt = 16'($urandom);
            repeat ($urandom_range(5, 0)) @(posedge clk);
            run_copy(($urandom % 2 == 0) ? 0 : 2, 1'($urandom % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_boot_loader.md
Name: flash_boot_loader

Overview:
Parametrised boot-time copier that moves a kernel image from 16-bit parallel NOR flash into 32-bit external SRAM before the CPU leaves reset.
- Successor to the ad-hoc loader inside the memory wrapper: clean FSM, configurable image size, flash access time, base addresses and SRAM write strobing.
- Sits between the board flash/SRAM pins and the memory wrapper. It owns the SRAM port while busy=1. The wrapper muxes the SRAM port back to the CPU on done=1.

Parameters:
- FLASH_AW, 22, flash halfword address width (drives flash A[22:1]).
- SRAM_AW, 20, SRAM word address width.
- WORD_COUNT, 4210, number of 32-bit words to copy; 0 is legal.
- WAIT_CYCLES, 8, clk cycles flash_oe_n is held low per halfword read; must be >= 1.
- SRC_BASE, 0, first flash halfword address.
- DST_BASE, 0, first SRAM word address.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to begin a copy
- flash_addr  out  FLASH_AW  halfword address
- flash_data_i  in  16  flash read data
- flash_ce_n  out  1  flash chip enable, active low
- flash_oe_n  out  1  flash output enable, active low
- flash_we_n  out  1  tied 1 (read-only)
- flash_rp_n  out  1  flash reset-powerdown, 0 during rst, else 1
- flash_byte_n  out  1  tied 1 (x16 mode)
- flash_vpen  out  1  tied 0
- sram_addr  out  SRAM_AW  word address
- sram_wdata  out  32  write data
- sram_be_n  out  4  byte enables, 4'b0000 while writing, else 4'b1111
- sram_ce_n / sram_oe_n / sram_we_n  out  1 each  SRAM strobes, active low; sram_oe_n always 1
- busy  out  1  copy in progress
- done  out  1  sticky: copy finished
- word_cnt  out  $clog2(WORD_COUNT+1)  words written so far

Behaviour:
- Reset, and the first clk edge with rst=1 from any state:
  - state=IDLE; busy=0, done=0, word_cnt=0.
  - All active-low strobes =1; flash_rp_n=0.
  - flash_addr=SRC_BASE, sram_addr=DST_BASE, sram_wdata=0.
  - A reset mid-copy abandons the copy immediately. No partial SRAM write may occur: sram_we_n is 1 on that edge.
- FSM states: IDLE, RD_LO, RD_HI, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE, start=1:
  - WORD_COUNT=0: go to DONE directly (done=1 after one edge).
  - Otherwise: go to RD_LO with busy=1, word_cnt=0, wait counter=WAIT_CYCLES-1.
- RD_LO:
  - flash_ce_n=0, flash_oe_n=0, flash_addr=SRC_BASE+2*word_cnt.
  - Counter decrements each cycle. In the cycle it reads 0, capture flash_data_i into data[15:0], reload the counter, go to RD_HI.
- RD_HI: same as RD_LO, with flash_addr=SRC_BASE+2*word_cnt+1. Capture into data[31:16], go to WR_SETUP.
- WR_SETUP:
  - flash strobes =1, sram_ce_n=0, sram_we_n=1.
  - sram_addr=DST_BASE+word_cnt, sram_wdata=data, sram_be_n=0.
  - One cycle.
- WR_PULSE: sram_we_n=0; addr and data stable; one cycle.
- WR_HOLD:
  - sram_we_n=1; addr and data still stable; one cycle; word_cnt increments.
  - If the new word_cnt==WORD_COUNT, go to DONE; else go to RD_LO.
- DONE:
  - busy=0, done=1; all strobes =1.
  - start=1 clears done and restarts the copy, exactly as from IDLE.
- Timing:
  - 2*WAIT_CYCLES+3 cycles per word.
  - done asserts on edge WORD_COUNT*(2*WAIT_CYCLES+3)+1, counted from the edge that samples start.
- start while busy=1 is ignored.
- Address arithmetic wraps modulo 2^FLASH_AW and 2^SRAM_AW; no error is flagged.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared defines header gets:
  - FSM state encodings for the loader.
  - Board pin polarities (FLASH_X16, active-low strobe constants).
  - KERNEL_WORDS default; the memory wrapper and the top level use the same value.
- One sub-module is natural: flash_wait_timer, a loadable down-counter with a zero flag. All other logic stays in one module.

Test Plan:
- WORD_COUNT=3, WAIT_CYCLES=2, flash model holds data=address:
  - Pulse start → SRAM words 0..2 = 32'h0001_0000, 32'h0003_0002, 32'h0005_0004.
  - done rises exactly 22 edges after start; word_cnt=3.
- Strobe timing check:
  - sram_we_n low exactly 1 cycle per word.
  - sram_addr/sram_wdata stable from the WR_SETUP cycle through WR_HOLD.
  - flash_oe_n and sram_ce_n never both low in the same cycle.
- rst asserted in WR_PULSE of word 1:
  - Next edge: sram_we_n=1, busy=0, word_cnt=0.
  - A fresh start recopies from word 0 correctly.
- WORD_COUNT=0, start pulse → done=1 one edge later; no flash or SRAM strobe ever goes low.
- start re-pulsed while busy=1 → ignored; timing unchanged.
- start pulsed in DONE → done=0 next edge, full copy repeats.
- SRC_BASE=22'h3F_FFFE, DST_BASE=20'hFFFFF, WORD_COUNT=2:
  - Flash halfword address wraps to 0.
  - Second SRAM write lands at address 0.
